// File: rtl/keypad_entry_ctrl_if.sv
// rtl/keypad_entry_ctrl_if.sv - keypad scanner input and code-entry status bundle
interface keypad_entry_ctrl_if;
  logic        sample_en;
  logic [11:0] key_data;
  logic [15:0] code_bcd;
  logic [2:0]  digit_count;
  logic        unlock;
  logic        code_ok;
  logic        code_err;
  logic        locked;

  modport master (
    output sample_en, key_data,
    input  code_bcd, digit_count, unlock, code_ok, code_err, locked
  );

  modport slave (
    input  sample_en, key_data,
    output code_bcd, digit_count, unlock, code_ok, code_err, locked
  );
endinterface

// File: rtl/keypad_entry_ctrl.sv
// rtl/keypad_entry_ctrl.sv - debounced keypad code entry with unlock; KEYPAD_LOCKOUT_EN adds failure lockout
module keypad_entry_ctrl #(
  parameter int              DEBOUNCE_CNT = 4,
  parameter int              MAX_DIGITS   = 4,
  parameter logic [15:0]     PASSCODE     = 16'h1234,
  parameter int              LOCK_SAMPLES = 1000
) (
  input  logic               clk,
  input  logic               rst,
  keypad_entry_ctrl_if.slave kp
);

  localparam logic [1:0] RELEASED  = 2'd0;
  localparam logic [1:0] PRESS_CHK = 2'd1;
  localparam logic [1:0] HELD      = 2'd2;
  localparam logic [1:0] REL_CHK   = 2'd3;

  localparam logic [3:0]  DC        = 4'(DEBOUNCE_CNT);
  localparam logic [2:0]  MAXD      = 3'(MAX_DIGITS);
  localparam logic [15:0] CODE_MASK = 16'((32'h1 << (MAX_DIGITS * 4)) - 32'h1);
  localparam logic [15:0] PASS_M    = PASSCODE & CODE_MASK;
  localparam logic [3:0]  KEY_STAR  = 4'd9;
  localparam logic [3:0]  KEY_ZERO  = 4'd10;
  localparam logic [3:0]  KEY_HASH  = 4'd11;

  logic        key_valid;
  logic [3:0]  key_idx;

  logic [1:0]  state;
  logic [3:0]  cnt;
  logic [3:0]  cnt_inc;
  logic [3:0]  cur_key;
  logic        armed;
  logic        key_evt;
  logic [3:0]  evt_key;
  logic        evt_live;

  logic [15:0] code_r;
  logic [2:0]  digits_r;
  logic        unlock_r;
  logic        ok_r;
  logic        err_r;
  logic        locked_r;

  logic        is_digit;
  logic [3:0]  digit_val;
  logic        hash_ok;

  always_comb begin
    key_valid = (kp.key_data != 12'd0) &&
                ((kp.key_data & (kp.key_data - 12'd1)) == 12'd0);
    key_idx = 4'd0;
    for (int i = 0; i < 12; i++) begin
      if (kp.key_data[i]) key_idx = 4'(i);
    end
  end

  assign cnt_inc = cnt + 4'd1;

  // After reset the controller stays disarmed until DEBOUNCE_CNT idle samples
  // have been seen, so a key still held across reset never produces an event.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= RELEASED;
      cnt     <= 4'd0;
      cur_key <= 4'd0;
      armed   <= 1'b0;
      key_evt <= 1'b0;
      evt_key <= 4'd0;
    end else begin
      key_evt <= 1'b0;
      if (kp.sample_en) begin
        case (state)
          RELEASED: begin
            if (!armed) begin
              if (key_valid) begin
                cnt <= 4'd0;
              end else if (cnt_inc >= DC) begin
                armed <= 1'b1;
                cnt   <= 4'd0;
              end else begin
                cnt <= cnt_inc;
              end
            end else if (key_valid) begin
              cur_key <= key_idx;
              if (DC == 4'd1) begin
                key_evt <= 1'b1;
                evt_key <= key_idx;
                state   <= HELD;
                cnt     <= 4'd0;
              end else begin
                cnt   <= 4'd1;
                state <= PRESS_CHK;
              end
            end
          end
          PRESS_CHK: begin
            if (!key_valid) begin
              state <= RELEASED;
              cnt   <= 4'd0;
            end else if (key_idx != cur_key) begin
              cur_key <= key_idx;
              cnt     <= 4'd1;
            end else if (cnt_inc == DC) begin
              key_evt <= 1'b1;
              evt_key <= cur_key;
              state   <= HELD;
              cnt     <= 4'd0;
            end else begin
              cnt <= cnt_inc;
            end
          end
          HELD: begin
            if (!key_valid) begin
              if (DC == 4'd1) begin
                state <= RELEASED;
                cnt   <= 4'd0;
              end else begin
                state <= REL_CHK;
                cnt   <= 4'd1;
              end
            end
          end
          default: begin
            if (key_valid) begin
              state <= HELD;
              cnt   <= 4'd0;
            end else if (cnt_inc == DC) begin
              state <= RELEASED;
              cnt   <= 4'd0;
            end else begin
              cnt <= cnt_inc;
            end
          end
        endcase
      end
    end
  end

  always_comb begin
    is_digit  = (evt_key <= 4'd8) || (evt_key == KEY_ZERO);
    digit_val = (evt_key == KEY_ZERO) ? 4'd0 : (evt_key + 4'd1);
    hash_ok   = (digits_r == MAXD) && (code_r == PASS_M);
  end

`ifdef KEYPAD_LOCKOUT_EN
  localparam int LW = $clog2(LOCK_SAMPLES + 1);

  logic [1:0]    fail_cnt;
  logic [LW-1:0] lock_cnt;

  // lock_cnt counts down the remaining sample_en ticks of the lockout.
  always_ff @(posedge clk) begin
    if (rst) begin
      fail_cnt <= 2'd0;
      lock_cnt <= '0;
      locked_r <= 1'b0;
    end else if (locked_r) begin
      if (kp.sample_en) begin
        if (lock_cnt == LW'(1)) begin
          locked_r <= 1'b0;
          fail_cnt <= 2'd0;
          lock_cnt <= '0;
        end else begin
          lock_cnt <= lock_cnt - LW'(1);
        end
      end
    end else if (key_evt && (evt_key == KEY_HASH)) begin
      if (hash_ok) begin
        fail_cnt <= 2'd0;
      end else if (fail_cnt == 2'd2) begin
        fail_cnt <= 2'd3;
        locked_r <= 1'b1;
        lock_cnt <= LW'(LOCK_SAMPLES);
      end else begin
        fail_cnt <= fail_cnt + 2'd1;
      end
    end
  end

  assign evt_live = key_evt && !locked_r;
`else
  assign locked_r = 1'b0;
  assign evt_live = key_evt;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      code_r   <= 16'd0;
      digits_r <= 3'd0;
      unlock_r <= 1'b0;
      ok_r     <= 1'b0;
      err_r    <= 1'b0;
    end else begin
      ok_r  <= 1'b0;
      err_r <= 1'b0;
      if (evt_live) begin
        if (is_digit) begin
          if (digits_r < MAXD) begin
            code_r   <= {code_r[11:0], digit_val} & CODE_MASK;
            digits_r <= digits_r + 3'd1;
          end
        end else if (evt_key == KEY_STAR) begin
          code_r   <= 16'd0;
          digits_r <= 3'd0;
          unlock_r <= 1'b0;
        end else if (evt_key == KEY_HASH) begin
          code_r   <= 16'd0;
          digits_r <= 3'd0;
          if (hash_ok) begin
            unlock_r <= 1'b1;
            ok_r     <= 1'b1;
          end else begin
            unlock_r <= 1'b0;
            err_r    <= 1'b1;
          end
        end
      end
    end
  end

  assign kp.code_bcd    = code_r;
  assign kp.digit_count = digits_r;
  assign kp.unlock      = unlock_r;
  assign kp.code_ok     = ok_r;
  assign kp.code_err    = err_r;
  assign kp.locked      = locked_r;

endmodule

// File: tb/tb_keypad_entry_ctrl.sv
// tb/tb_keypad_entry_ctrl.sv - directed vector bench for keypad_entry_ctrl
module tb_keypad_entry_ctrl;

  localparam int LOCK_SAMPLES = 100;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  keypad_entry_ctrl_if bus ();

  keypad_entry_ctrl #(
    .DEBOUNCE_CNT (4),
    .MAX_DIGITS   (4),
    .PASSCODE     (16'h1234),
    .LOCK_SAMPLES (LOCK_SAMPLES)
  ) dut (
    .clk (clk),
    .rst (rst),
    .kp  (bus.slave)
  );

  typedef struct {
    logic [11:0] k1;
    int          n1;
    logic [11:0] k2;
    int          n2;
    int          nrel;
    logic [15:0] code;
    logic [2:0]  cnt;
    logic        unl;
    int          oks;
    int          errs;
  } row_t;

  localparam logic [11:0] K_STAR = 12'h200;
  localparam logic [11:0] K_HASH = 12'h800;

  int total = 0;
  int bad   = 0;
  int ok_n  = 0;
  int err_n = 0;
  logic both_seen   = 1'b0;
  logic locked_seen = 1'b0;
  row_t rows[$];

  always @(negedge clk) begin
    if (bus.code_ok)  ok_n  = ok_n + 1;
    if (bus.code_err) err_n = err_n + 1;
    if (bus.code_ok && bus.code_err) both_seen = 1'b1;
    if (bus.locked) locked_seen = 1'b1;
  end

  function automatic logic [11:0] key(input int d);
    logic [11:0] one;
    one = 12'h001;
    return (d == 0) ? 12'h400 : (one << (d - 1));
  endfunction

  function automatic row_t mk(input logic [11:0] k1, input int n1, input logic [11:0] k2,
                              input int n2, input logic [15:0] code, input logic [2:0] cnt,
                              input logic unl, input int oks, input int errs);
    row_t r;
    r.k1 = k1; r.n1 = n1; r.k2 = k2; r.n2 = n2; r.nrel = 6;
    r.code = code; r.cnt = cnt; r.unl = unl; r.oks = oks; r.errs = errs;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total = total + 1;
    if (act !== exp) begin
      bad = bad + 1;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic smp(input logic [11:0] k);
    @(negedge clk);
    bus.key_data  = k;
    bus.sample_en = 1'b1;
    @(negedge clk);
    bus.sample_en = 1'b0;
  endtask

  task automatic smp_n(input logic [11:0] k, input int n);
    for (int i = 0; i < n; i++) smp(k);
  endtask

  task automatic press(input logic [11:0] k);
    smp_n(k, 6);
    smp_n(12'h000, 6);
  endtask

  task automatic check_state(input string tag, input logic [15:0] code, input logic [2:0] cnt,
                             input logic unl);
    chk({tag, ".code"},   32'(bus.code_bcd),    32'(code));
    chk({tag, ".count"},  32'(bus.digit_count), 32'(cnt));
    chk({tag, ".unlock"}, 32'(bus.unlock),      32'(unl));
  endtask

  initial begin
    int ok0;
    int err0;
    int waited;

    bus.sample_en = 1'b0;
    bus.key_data  = 12'h000;

    rows.push_back(mk(key(1), 6, 12'h0, 0, 16'h0001, 3'd1, 1'b0, 0, 0));
    rows.push_back(mk(key(2), 6, 12'h0, 0, 16'h0012, 3'd2, 1'b0, 0, 0));
    rows.push_back(mk(key(3), 6, 12'h0, 0, 16'h0123, 3'd3, 1'b0, 0, 0));
    rows.push_back(mk(key(4), 6, 12'h0, 0, 16'h1234, 3'd4, 1'b0, 0, 0));
    rows.push_back(mk(K_HASH, 6, 12'h0, 0, 16'h0000, 3'd0, 1'b1, 1, 0));
    rows.push_back(mk(key(1), 3, 12'h0, 0, 16'h0000, 3'd0, 1'b1, 0, 0));
    rows.push_back(mk(key(5), 50, 12'h0, 0, 16'h0005, 3'd1, 1'b1, 0, 0));
    rows.push_back(mk(K_STAR, 6, 12'h0, 0, 16'h0000, 3'd0, 1'b0, 0, 0));
    rows.push_back(mk(key(9), 6, 12'h0, 0, 16'h0009, 3'd1, 1'b0, 0, 0));
    rows.push_back(mk(key(8), 6, 12'h0, 0, 16'h0098, 3'd2, 1'b0, 0, 0));
    rows.push_back(mk(key(7), 6, 12'h0, 0, 16'h0987, 3'd3, 1'b0, 0, 0));
    rows.push_back(mk(key(6), 6, 12'h0, 0, 16'h9876, 3'd4, 1'b0, 0, 0));
    rows.push_back(mk(key(5), 6, 12'h0, 0, 16'h9876, 3'd4, 1'b0, 0, 0));
    rows.push_back(mk(K_HASH, 6, 12'h0, 0, 16'h0000, 3'd0, 1'b0, 0, 1));
    rows.push_back(mk(12'h003, 10, 12'h0, 0, 16'h0000, 3'd0, 1'b0, 0, 0));
    rows.push_back(mk(key(0), 6, 12'h0, 0, 16'h0000, 3'd1, 1'b0, 0, 0));
    rows.push_back(mk(K_HASH, 6, 12'h0, 0, 16'h0000, 3'd0, 1'b0, 0, 1));
    rows.push_back(mk(key(1), 6, 12'h0, 0, 16'h0001, 3'd1, 1'b0, 0, 0));
    rows.push_back(mk(key(2), 6, 12'h0, 0, 16'h0012, 3'd2, 1'b0, 0, 0));
    rows.push_back(mk(key(3), 6, 12'h0, 0, 16'h0123, 3'd3, 1'b0, 0, 0));
    rows.push_back(mk(key(4), 6, 12'h0, 0, 16'h1234, 3'd4, 1'b0, 0, 0));
    rows.push_back(mk(K_HASH, 6, 12'h0, 0, 16'h0000, 3'd0, 1'b1, 1, 0));
    rows.push_back(mk(K_HASH, 6, 12'h0, 0, 16'h0000, 3'd0, 1'b0, 0, 1));
    rows.push_back(mk(key(7), 2, key(8), 4, 16'h0008, 3'd1, 1'b0, 0, 0));
    rows.push_back(mk(12'h801, 8, 12'h0, 0, 16'h0008, 3'd1, 1'b0, 0, 0));

    repeat (3) @(negedge clk);
    check_state("reset", 16'h0000, 3'd0, 1'b0);
    chk("reset.code_ok",  32'(bus.code_ok),  32'd0);
    chk("reset.code_err", 32'(bus.code_err), 32'd0);
    chk("reset.locked",   32'(bus.locked),   32'd0);
    rst = 1'b0;
    smp_n(12'h000, 6);

    for (int r = 0; r < rows.size(); r++) begin
      ok0  = ok_n;
      err0 = err_n;
      smp_n(rows[r].k1, rows[r].n1);
      smp_n(rows[r].k2, rows[r].n2);
      smp_n(12'h000, rows[r].nrel);
      check_state($sformatf("row%0d", r), rows[r].code, rows[r].cnt, rows[r].unl);
      chk($sformatf("row%0d.ok_pulses", r),  32'(ok_n - ok0),   32'(rows[r].oks));
      chk($sformatf("row%0d.err_pulses", r), 32'(err_n - err0), 32'(rows[r].errs));
    end

    bus.key_data = key(9);
    repeat (40) @(negedge clk);
    bus.key_data = 12'h000;
    check_state("no_strobe", 16'h0008, 3'd1, 1'b0);

    smp_n(key(3), 3);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    check_state("midpress_rst", 16'h0000, 3'd0, 1'b0);
    smp_n(key(3), 10);
    chk("midpress_held.count", 32'(bus.digit_count), 32'd0);
    smp_n(12'h000, 6);
    press(key(3));
    check_state("after_repress", 16'h0003, 3'd1, 1'b0);

    smp_n(key(2), 3);
    @(negedge clk);
    bus.key_data  = key(2);
    bus.sample_en = 1'b1;
    @(posedge clk);
    #1;
    bus.sample_en = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check_state("pending_evt_rst", 16'h0000, 3'd0, 1'b0);
    smp_n(key(2), 6);
    smp_n(12'h000, 6);
    chk("pending_evt_held.count", 32'(bus.digit_count), 32'd0);

`ifdef KEYPAD_LOCKOUT_EN
    press(K_HASH);
    press(K_HASH);
    chk("lock.two_fails", 32'(bus.locked), 32'd0);
    press(K_HASH);
    chk("lock.third_fail", 32'(bus.locked), 32'd1);
    ok0 = ok_n;
    press(key(1)); press(key(2)); press(key(3)); press(key(4)); press(K_HASH);
    chk("lock.ignored_ok", 32'(ok_n - ok0), 32'd0);
    check_state("lock.ignored", 16'h0000, 3'd0, 1'b0);
    chk("lock.still", 32'(bus.locked), 32'd1);
    waited = 0;
    while (bus.locked && waited < 300) begin
      smp(12'h000);
      waited = waited + 1;
    end
    chk("lock.expired", 32'(bus.locked), 32'd0);
    chk("lock.duration_ok", 32'(waited > 30 && waited < 50), 32'd1);
    press(K_HASH);
    press(key(1)); press(key(2)); press(key(3)); press(key(4));
    ok0 = ok_n;
    press(K_HASH);
    chk("lock.after_ok", 32'(ok_n - ok0), 32'd1);
    chk("lock.after_unlock", 32'(bus.unlock), 32'd1);
    chk("lock.after_locked", 32'(bus.locked), 32'd0);
    chk("lock.seen", 32'(locked_seen), 32'd1);
`else
    press(K_HASH); press(K_HASH); press(K_HASH);
    chk("nolock.locked", 32'(locked_seen), 32'd0);
    press(key(1)); press(key(2)); press(key(3)); press(key(4));
    ok0 = ok_n;
    press(K_HASH);
    chk("nolock.ok", 32'(ok_n - ok0), 32'd1);
    chk("nolock.unlock", 32'(bus.unlock), 32'd1);
`endif

    chk("ok_err_exclusive", 32'(both_seen), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/keypad_entry_ctrl.md
KEYPAD_ENTRY_CTRL -- requirements
Module: keypad_entry_ctrl

Interface
REQ-001 Parameter DEBOUNCE_CNT, default 4: consecutive identical sample_en samples needed to accept a press or a release (range 1..15).
REQ-002 Parameter MAX_DIGITS, default 4: code length in digits (range 1..4).
REQ-003 Parameter PASSCODE, default 16'h1234: expected code in BCD, right-aligned, most significant digit entered first.
REQ-004 Parameter LOCK_SAMPLES, default 1000: lockout duration in sample_en ticks.
REQ-005 clk  in  1  single system clock; all logic on its rising edge.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 sample_en  in  1  one-cycle strobe; key_data is sampled only when this is high.
REQ-008 key_data  in  12  one-hot key from the scanner: bits 0..8 = keys 1..9, bit 9 = '*', bit 10 = '0', bit 11 = '#'; all-zero = no key.
REQ-009 code_bcd  out  16  digits entered so far, BCD, newest digit in bits [3:0].
REQ-010 digit_count  out  3  number of digits held, 0..MAX_DIGITS.
REQ-011 unlock  out  1  level; high after a correct code.
REQ-012 code_ok  out  1  one-cycle pulse on a correct '#'.
REQ-013 code_err  out  1  one-cycle pulse on an incorrect '#'.
REQ-014 locked  out  1  level; high during lockout.

Function
REQ-015 Any key_data value that is not exactly one-hot, including zero, is sampled as "no key".
REQ-016 Debounce FSM states and transitions:
- RELEASED: wait for a key.
- PRESS_CHK: counting DEBOUNCE_CNT consecutive samples of the same key; a different key restarts the count at 1; "no key" returns to RELEASED.
- HELD: key accepted.
- REL_CHK: counting DEBOUNCE_CNT consecutive "no key" samples, then back to RELEASED; any key sample returns to HELD.
REQ-017 Exactly one key event is generated per press, on the clk edge where PRESS_CHK reaches DEBOUNCE_CNT; holding the key never repeats the event.
REQ-018 Outputs update on the edge after the key event (latency 1 clk).
REQ-019 Digit event with digit_count < MAX_DIGITS: code_bcd <= {code_bcd[11:0], digit}; digit_count increments.
REQ-020 Digit event with digit_count == MAX_DIGITS is ignored; no output changes.
REQ-021 '*' event: code_bcd, digit_count and unlock all clear to 0.
REQ-022 '#' event with digit_count == MAX_DIGITS and code_bcd == PASSCODE: unlock <= 1 and code_ok pulses.
REQ-023 '#' event in any other case (wrong code or short entry): code_err pulses and unlock <= 0.
REQ-024 Every '#' event clears code_bcd and digit_count.
REQ-025 unlock holds until a '*' event, an incorrect '#' event, or rst.
REQ-026 code_ok and code_err are never high in the same cycle.
REQ-027 Bits of code_bcd above MAX_DIGITS*4 stay 0.

Reset
REQ-028 While rst is high on a clk edge, all outputs go to 0, the debounce FSM goes to RELEASED, and all counters clear.
REQ-029 rst mid-press discards the press; the key must be released (REL_CHK complete) and pressed again to generate a new event.
REQ-030 rst takes priority over sample_en and over any pending key event.

Configuration
REQ-031 Macro KEYPAD_LOCKOUT_EN defined: a 2-bit fail counter counts consecutive incorrect '#' events.
REQ-032 The third consecutive failure sets locked = 1 for LOCK_SAMPLES sample_en ticks.
REQ-033 While locked, all key events are discarded.
REQ-034 When the lockout expires, locked clears and the fail counter clears.
REQ-035 A correct '#' event clears the fail counter.
REQ-036 Macro KEYPAD_LOCKOUT_EN undefined: locked is tied to 0 and no fail counter or lockout counter exists.

Verification
REQ-037 Press '1','2','3','4','#', each held for 6 samples and released for 6 samples -> code_ok pulses once, unlock = 1, digit_count = 0.
REQ-038 Press '1' for 3 samples only, then release (DEBOUNCE_CNT = 4) -> no event, code_bcd = 0.
REQ-039 Hold '5' for 50 samples -> exactly one event: code_bcd = 16'h0005, digit_count = 1.
REQ-040 Enter '9','8','7','6','5','#' -> the fifth digit is ignored, code_bcd = 16'h9876 before '#', then code_err pulses.
REQ-041 Apply key_data = 12'h003 for 10 samples -> treated as no key, no event.
REQ-042 KEYPAD_LOCKOUT_EN defined: three wrong codes -> locked = 1; the correct code entered during lockout is ignored; locked clears after LOCK_SAMPLES ticks.
